// File: rtl/neural_network_pkg.sv
// Shared parameters, Q-format types and saturation limits for the neural_network accelerator.
package nn_pkg;

    localparam int NU_COUNT = 4;
    localparam int Q_INT    = 8;
    localparam int Q_FRAC   = 8;
    localparam int IN_DEPTH = 16;

    localparam int Q_W   = Q_INT + Q_FRAC;
    localparam int NU_W  = $clog2(NU_COUNT);
    localparam int IDX_W = $clog2(IN_DEPTH);

    typedef logic signed [Q_INT-1:-Q_FRAC]     q_t;
    typedef logic signed [2*Q_INT-1:-2*Q_FRAC] q2_t;

    localparam q_t Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
    localparam q_t Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

    function automatic q_t relu(input q_t v);
        return v[Q_INT-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/neural_network_if.sv
// Weight-load, input-stream and result bus of the neural_network accelerator.
interface neural_network_if;
    import nn_pkg::*;

    logic                      w_we;
    logic [NU_W-1:0]           w_unit;
    logic [IDX_W-1:0]          w_addr;
    q_t                        w_data;
    logic                      start;
    logic                      x_valid;
    q_t                        x_data;
    logic                      x_last;
    logic                      out_valid;
    logic [NU_COUNT*Q_W-1:0]   out_data;
    logic [2*NU_COUNT-1:0]     prod_ovf;
    logic [2*NU_COUNT-1:0]     sum_ovf;

    modport master (
        output w_we, w_unit, w_addr, w_data, start, x_valid, x_data, x_last,
        input  out_valid, out_data, prod_ovf, sum_ovf
    );

    modport slave (
        input  w_we, w_unit, w_addr, w_data, start, x_valid, x_data, x_last,
        output out_valid, out_data, prod_ovf, sum_ovf
    );

endinterface

// File: rtl/neural_network_mac_unit.sv
// One neuron: local weight table, signed Q multiply with truncate/saturate,
// saturating accumulator and sticky {neg,pos} product/sum overflow flags.
module mac_unit
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             w_we,
    input  logic [IDX_W-1:0] w_addr,
    input  q_t               w_data,
    input  logic             start,
    input  logic             x_valid,
    input  q_t               x_data,
    input  logic [IDX_W-1:0] rd_idx,
    output q_t               mac_d_o,
    output logic [1:0]       prod_ovf_o,
    output logic [1:0]       sum_ovf_o
);

    q_t                    weight_q [IN_DEPTH];
    q2_t                   prod_full;
    logic signed [2*Q_W-1:0] prod_sh;
    logic [Q_W:0]          prod_hi;
    q_t                    prod_q;
    q_t                    mac_reg;
    q_t                    mac_base;
    q_t                    sum_raw;
    q_t                    mac_d;
    logic                  prod_pos_hit, prod_neg_hit;
    logic                  sum_pos_hit, sum_neg_hit;
    logic                  prod_pos_overflow, prod_neg_overflow;
    logic                  sum_pos_overflow, sum_neg_overflow;

    always_comb begin
        prod_full = q2_t'(x_data) * q2_t'(weight_q[rd_idx]);
        // After dropping Q_FRAC bits, the result fits in Q only if everything
        // from the Q sign bit upwards is a copy of the product sign.
        prod_sh      = prod_full >>> Q_FRAC;
        prod_hi      = prod_sh[2*Q_W-1:Q_W-1];
        prod_pos_hit = !prod_sh[2*Q_W-1] && (|prod_hi);
        prod_neg_hit =  prod_sh[2*Q_W-1] && !(&prod_hi);
        if (prod_pos_hit)      prod_q = Q_MAX;
        else if (prod_neg_hit) prod_q = Q_MIN;
        else                   prod_q = q_t'(prod_sh[Q_W-1:0]);

        mac_base    = start ? '0 : mac_reg;
        sum_raw     = mac_base + prod_q;
        sum_pos_hit = !mac_base[Q_INT-1] && !prod_q[Q_INT-1] &&  sum_raw[Q_INT-1];
        sum_neg_hit =  mac_base[Q_INT-1] &&  prod_q[Q_INT-1] && !sum_raw[Q_INT-1];

        mac_d = mac_base;
        if (x_valid) begin
            if (sum_pos_hit)      mac_d = Q_MAX;
            else if (sum_neg_hit) mac_d = Q_MIN;
            else                  mac_d = sum_raw;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IN_DEPTH; i++) weight_q[i] <= '0;
        end else if (w_we) begin
            weight_q[w_addr] <= w_data;
        end
    end

    // Flags are sticky; start clears them but the beat accepted with start still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_reg           <= '0;
            prod_pos_overflow <= 1'b0;
            prod_neg_overflow <= 1'b0;
            sum_pos_overflow  <= 1'b0;
            sum_neg_overflow  <= 1'b0;
        end else begin
            mac_reg           <= mac_d;
            prod_pos_overflow <= (prod_pos_overflow & ~start) | (x_valid & prod_pos_hit);
            prod_neg_overflow <= (prod_neg_overflow & ~start) | (x_valid & prod_neg_hit);
            sum_pos_overflow  <= (sum_pos_overflow  & ~start) | (x_valid & sum_pos_hit);
            sum_neg_overflow  <= (sum_neg_overflow  & ~start) | (x_valid & sum_neg_hit);
        end
    end

    assign mac_d_o    = mac_d;
    assign prod_ovf_o = {prod_neg_overflow, prod_pos_overflow};
    assign sum_ovf_o  = {sum_neg_overflow, sum_pos_overflow};

endmodule

// File: rtl/neural_network.sv
// Single-layer fully-connected accelerator: NU_COUNT MAC units share one input stream.
// Optional macro RELU_EN clamps negative output lanes to zero.
module neural_network
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    neural_network_if.slave  bus
);

    logic [IDX_W-1:0]        idx_q, idx_d, idx_base;
    logic                    last_beat;
    logic                    out_valid_q;
    logic [NU_COUNT*Q_W-1:0] out_data_q, out_data_d;

    // A start beat is element 0; reaching the last weight index ends the vector implicitly.
    always_comb begin
        idx_base  = bus.start ? '0 : idx_q;
        last_beat = bus.x_valid && (bus.x_last || idx_base == IDX_W'(IN_DEPTH-1));
        idx_d     = idx_base;
        if (bus.x_valid) idx_d = last_beat ? '0 : idx_base + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= last_beat;
            if (last_beat) out_data_q <= out_data_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NU_COUNT; gi++) begin : mac_gen
            q_t mac_next;

            mac_unit mac_unit (
                .clk        (clk),
                .reset      (reset),
                .w_we       (bus.w_we && bus.w_unit == NU_W'(gi)),
                .w_addr     (bus.w_addr),
                .w_data     (bus.w_data),
                .start      (bus.start),
                .x_valid    (bus.x_valid),
                .x_data     (bus.x_data),
                .rd_idx     (idx_base),
                .mac_d_o    (mac_next),
                .prod_ovf_o (bus.prod_ovf[2*gi +: 2]),
                .sum_ovf_o  (bus.sum_ovf[2*gi +: 2])
            );

`ifdef RELU_EN
            assign out_data_d[gi*Q_W +: Q_W] = relu(mac_next);
`else
            assign out_data_d[gi*Q_W +: Q_W] = mac_next;
`endif
        end
    endgenerate

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_neural_network.sv
// Self-checking bench for neural_network: directed Q8.8 scenarios plus random vectors
// checked against an integer-arithmetic model of the layer.
module tb_neural_network;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    neural_network_if bus();

    neural_network dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int wm [NU_COUNT][IN_DEPTH];
    int xv [IN_DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int s16(input int v);
        logic [15:0] t;
        t = 16'(v);
        return int'($signed(t));
    endfunction

    function automatic int clamp_q(input int v, output bit pos, output bit neg);
        pos = (v > 32767);
        neg = (v < -32768);
        if (pos) return 32767;
        if (neg) return -32768;
        return v;
    endfunction

    function automatic int rand_q();
        if ($urandom_range(0, 3) == 0) return s16(int'($urandom));
        return int'($urandom_range(0, 1536)) - 768;
    endfunction

    task automatic idle_inputs();
        bus.w_we    = 1'b0;
        bus.w_unit  = '0;
        bus.w_addr  = '0;
        bus.w_data  = '0;
        bus.start   = 1'b0;
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.x_last  = 1'b0;
    endtask

    task automatic write_w(input int u, input int a, input int d);
        @(negedge clk);
        bus.w_we   = 1'b1;
        bus.w_unit = NU_W'(u);
        bus.w_addr = IDX_W'(a);
        bus.w_data = 16'(d);
        @(negedge clk);
        bus.w_we   = 1'b0;
        wm[u][a]   = s16(d);
    endtask

    // Drives one vector starting with start, then checks the result pulse and hold.
    task automatic run_vector(input int n, input bit with_last, input string name);
        int acc [NU_COUNT];
        logic [2*NU_COUNT-1:0] eprod, esum;
        logic [NU_COUNT*Q_W-1:0] edata;
        bit early;
        bit pp, pn, sp, sn;
        int p, e;
        eprod = '0;
        esum  = '0;
        edata = '0;
        early = 1'b0;
        for (int j = 0; j < NU_COUNT; j++) begin
            acc[j] = 0;
            for (int i = 0; i < n; i++) begin
                p = clamp_q((xv[i] * wm[j][i]) >>> 8, pp, pn);
                acc[j] = clamp_q(acc[j] + p, sp, sn);
                eprod[2*j]   |= pp;
                eprod[2*j+1] |= pn;
                esum[2*j]    |= sp;
                esum[2*j+1]  |= sn;
            end
            e = acc[j];
`ifdef RELU_EN
            if (e < 0) e = 0;
`endif
            edata[j*Q_W +: Q_W] = 16'(e);
        end

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.out_valid) early = 1'b1;
            bus.start   = (i == 0);
            bus.x_valid = 1'b1;
            bus.x_data  = 16'(xv[i]);
            bus.x_last  = with_last && (i == n - 1);
        end
        @(negedge clk);
        idle_inputs();

        n_checks++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early_valid: got 1 required 0", name);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b required 1", name, bus.out_valid);
        end
        n_checks++;
        if (bus.out_data !== edata) begin
            n_fail++;
            $display("FAIL %s out_data: got %h required %h", name, bus.out_data, edata);
        end
        n_checks++;
        if (bus.prod_ovf !== eprod) begin
            n_fail++;
            $display("FAIL %s prod_ovf: got %b required %b", name, bus.prod_ovf, eprod);
        end
        n_checks++;
        if (bus.sum_ovf !== esum) begin
            n_fail++;
            $display("FAIL %s sum_ovf: got %b required %b", name, bus.sum_ovf, esum);
        end

        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== edata || bus.sum_ovf !== esum) begin
            n_fail++;
            $display("FAIL %s hold: got valid=%b data=%h sum_ovf=%b required valid=0 data=%h sum_ovf=%b",
                     name, bus.out_valid, bus.out_data, bus.sum_ovf, edata, esum);
        end
        $display("vector %s n=%0d out_data=%h prod_ovf=%b sum_ovf=%b", name, n, edata, eprod, esum);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.prod_ovf !== '0 || bus.sum_ovf !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b data=%h prod=%b sum=%b required all 0",
                     bus.out_valid, bus.out_data, bus.prod_ovf, bus.sum_ovf);
        end
        reset = 1'b1;

        write_w(0, 0, 'h6400);
        write_w(1, 0, 'h0100);
        xv[0] = 'h0200;
        run_vector(1, 1'b1, "rst_pre");

        // Reset lands asynchronously in the middle of an accumulation.
        @(negedge clk);
        bus.start = 1'b1; bus.x_valid = 1'b1; bus.x_data = 16'h0200;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (dut.mac_gen[0].mac_unit.mac_reg !== '0 || dut.mac_gen[1].mac_unit.mac_reg !== '0) begin
            n_fail++;
            $display("FAIL reset_mac: got %h %h required 0000 0000",
                     dut.mac_gen[0].mac_unit.mac_reg, dut.mac_gen[1].mac_unit.mac_reg);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.prod_ovf !== '0 || bus.sum_ovf !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got valid=%b data=%h prod=%b sum=%b required all 0",
                     bus.out_valid, bus.out_data, bus.prod_ovf, bus.sum_ovf);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        for (int u = 0; u < NU_COUNT; u++)
            for (int a = 0; a < IN_DEPTH; a++) wm[u][a] = 0;
        $display("reset test done");
    endtask

    task automatic test_basic();
        for (int j = 0; j < NU_COUNT; j++) write_w(j, 0, (j + 1) * 'h0100);
        xv[0] = 'h0200;
        run_vector(1, 1'b1, "basic");
    endtask

    task automatic test_prod_ovf();
        xv[0] = 'h0200;
        write_w(0, 0, 'h6400);
        run_vector(1, 1'b1, "prod_pos");
        write_w(0, 0, 'h9C00);
        run_vector(1, 1'b1, "prod_neg");
    endtask

    task automatic test_sum_ovf();
        for (int i = 0; i < 3; i++) begin
            write_w(0, i, 'h0100);
            xv[i] = 'h4000;
        end
        run_vector(3, 1'b1, "sum_pos");
        xv[0] = 'h0100;
        run_vector(1, 1'b1, "sum_clear");
    endtask

    task automatic test_trunc();
        write_w(0, 0, 'h0080);
        xv[0] = 'h0001;
        run_vector(1, 1'b1, "trunc_pos");
        xv[0] = s16('hFFFF);
        run_vector(1, 1'b1, "trunc_neg");
    endtask

    task automatic test_implicit_last();
        for (int a = 0; a < IN_DEPTH; a++) begin
            write_w(0, a, int'($urandom_range(0, 255)));
            write_w(1, a, -int'($urandom_range(1, 255)));
            write_w(2, a, int'($urandom_range(0, 511)) - 256);
            write_w(3, a, int'($urandom_range(0, 511)) - 256);
        end
        for (int i = 0; i < IN_DEPTH; i++) xv[i] = int'($urandom_range(1, 512));
        run_vector(IN_DEPTH, 1'b0, "implicit_last");
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int n;
            for (int k = 0; k < 6; k++)
                write_w(int'($urandom_range(0, NU_COUNT-1)), int'($urandom_range(0, IN_DEPTH-1)), rand_q());
            n = int'($urandom_range(1, IN_DEPTH));
            for (int i = 0; i < n; i++) xv[i] = rand_q();
            run_vector(n, (n != IN_DEPTH) || ($urandom_range(0, 1) == 1), $sformatf("rand%0d", it));
        end
    endtask

    initial begin
        idle_inputs();
        for (int u = 0; u < NU_COUNT; u++)
            for (int a = 0; a < IN_DEPTH; a++) wm[u][a] = 0;
        test_reset();
        test_basic();
        test_prod_ovf();
        test_sum_ovf();
        test_trunc();
        test_implicit_last();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neural_network.md
Name: neural_network

Overview:
- Single-layer fully-connected accelerator with NU_COUNT parallel neuron units, each built around one signed fixed-point MAC.
- An input vector streams in one element per beat. Each element is broadcast to every unit and multiplied by that unit's locally stored weight for the current index. The product is accumulated with saturation.
- After the last element, all NU_COUNT accumulator results are presented together, along with sticky overflow flags.
- Sits between the host/DMA stream and the next layer or readout logic.

Parameters:
- NU_COUNT, 4, number of parallel neuron/MAC units.
- Q_INT, 8, integer bits (including sign) of the Q data format.
- Q_FRAC, 8, fractional bits of the Q data format; data word width Q_W = Q_INT+Q_FRAC.
- IN_DEPTH, 16, maximum input-vector length, i.e. weight entries per unit.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- w_we  in  1  weight write strobe.
- w_unit  in  $clog2(NU_COUNT)  target unit of the weight write.
- w_addr  in  $clog2(IN_DEPTH)  weight index.
- w_data  in  Q_W  signed Q weight.
- start  in  1  begins a new vector: clears accumulators, index and sticky flags.
- x_valid  in  1  input element valid.
- x_data  in  Q_W  signed Q input element.
- x_last  in  1  marks the final element of the vector.
- out_valid  out  1  one-cycle pulse: out_data is valid.
- out_data  out  NU_COUNT*Q_W  unit j occupies bits [j*Q_W +: Q_W].
- prod_ovf  out  2*NU_COUNT  sticky per-unit product overflow; {neg,pos} pair for unit j at bits [2j+1:2j].
- sum_ovf  out  2*NU_COUNT  sticky per-unit accumulator overflow, same packing.

Behaviour:
- Reset (reset=0, asynchronous):
  - all weights, mac_reg, index, out_valid, out_data and flags clear to 0.
- Weight write:
  - on a clock edge with w_we=1, W[w_unit][w_addr] <= w_data.
  - a read of the same entry in that same cycle returns the old value.
- Start:
  - on an edge with start=1: mac_reg <= 0, idx <= 0, all sticky flags cleared.
  - if x_valid=1 in the same cycle, that beat is accepted as element 0, so mac_reg <= sat(prod).
- Beat (x_valid=1), per unit j:
  - prod_full = x_data * W[j][idx], signed, width 2*Q_W, binary point at 2*Q_FRAC.
  - product to Q: take bits [Q_W+Q_FRAC-1 : Q_FRAC] of prod_full, i.e. truncate the low Q_FRAC bits (floor toward -inf).
  - positive product overflow: prod_full sign=0 and bits [2Q_W-1 : Q_W+Q_FRAC-1] not all equal. Result saturates to 0x7FF…F and sets prod_pos.
  - negative product overflow: same test with sign=1. Result saturates to 0x800…0 and sets prod_neg.
  - mac_reg <= mac_reg + prod_q with saturation.
  - positive sum overflow: both operands non-negative and the sum's sign is negative. Result → max, sets sum_pos.
  - negative sum overflow: the mirror case. Result → min, sets sum_neg.
  - idx increments.
- Last beat:
  - x_last=1, or a beat with idx==IN_DEPTH-1, ends the vector; the latter is an implicit last.
  - next cycle: out_valid=1 for exactly one cycle, out_data = final mac_reg values.
  - latency is 1 clock from the last beat's edge.
  - out_data holds until the next vector completes.
  - idx returns to 0.
- Beats with x_valid=0 are ignored.
- Beats after the last and before a new start begin a new vector: the accumulation continues from the current mac_reg at idx 0. Software should issue start.
- Writing a weight at the index in use during accumulation is legal; the change takes effect from the next cycle.
- Flags remain set until start or reset.

Optional Feature:
- Macro RELU_EN.
- Defined: each out_data lane is passed through ReLU; a negative mac_reg outputs 0. The registers and flags are unchanged.
- Undefined: out_data equals raw mac_reg.

Decomposition:
- Package nn_pkg holds:
  - NU_COUNT, Q_INT, Q_FRAC, IN_DEPTH defaults.
  - typedef q_t (signed [Q_INT-1:-Q_FRAC]).
  - typedef q2_t (signed [2*Q_INT-1:-2*Q_FRAC]).
  - constants Q_MAX and Q_MIN.
- Sub-module mac_unit, instantiated NU_COUNT times in a generate loop named mac_gen. It contains:
  - the multiply, truncate/saturate and saturating-add datapath;
  - the mac_reg register;
  - the four overflow flags.
- Hierarchical names mac_gen[j].mac_unit.{prod_full, mac_reg, prod_pos_overflow, prod_neg_overflow, sum_pos_overflow, sum_neg_overflow} must exist for probing.

Test Plan:
All values use Q8.8 (1.0 = 0x0100).
1. Reset: assert reset low mid-accumulation → mac_reg, out_data, out_valid and all flags read 0 immediately.
2. Basic: W[j][0] = (j+1)·1.0; start + single beat x=0x0200 with x_last → one cycle later out_valid=1 and lanes = 0x0200, 0x0400, 0x0600, 0x0800; no flags.
3. Product overflow: W[0][0]=0x6400 (100.0), x=0x0200 → lane0 = 0x7FFF, prod_pos set. With W=0x9C00 (−100.0) → lane0 = 0x8000, prod_neg set.
4. Sum overflow: W[0][0..2]=0x0100, three beats x=0x4000 (64.0) → lane0 = 0x7FFF, sum_pos set and still set after the vector; the next start clears it.
5. Truncation: W=0x0080 (0.5), x=0x0001 → lane 0x0000. With x=0xFFFF → lane 0xFFFF (floor of −1/512).
6. Implicit last/RELU_EN: IN_DEPTH beats without x_last → out_valid after beat 16. With RELU_EN, a negative result lane reads 0x0000.
